eth_rx_frame_checker: RTL and testbench

- Receive-side front end that sits directly upstream of the packet store (register memory plus length FIFO).
- Takes raw byte-wide MII/GMII-style receive data, detects preamble and SFD, and forwards frame bytes with a data-valid.
- Publishes its 3-bit FSM state so the packet store starts writing on the DELIMETER state.
- Checks CRC-32, frame length and receive errors, and raises a frame-error flag in the window where the packet store samples it to commit or drop the frame.

---
 rtl/eth_rx_frame_checker_if.sv | 26 ++
 rtl/eth_rx_frame_checker.sv | 164 ++++++++++++++++
 tb/tb_eth_rx_frame_checker.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_frame_checker_if.sv
// Receive-side bus of the frame checker: raw PHY byte stream in, forwarded
// stream plus frame status out.
interface eth_rx_frame_checker_if #(
  parameter int pDATA_WIDTH = 8,
  parameter int pLEN_WIDTH  = 11
);
  logic                   irx_dv;
  logic                   irx_er;
  logic [pDATA_WIDTH-1:0] irx_d;
  logic                   odv;
  logic [pDATA_WIDTH-1:0] orx_d;
  logic [2:0]             oFSM_state;
  logic                   o_error;
  logic                   o_frame_good;
  logic [pLEN_WIDTH-1:0]  o_frame_len;

  modport master (
    output irx_dv, irx_er, irx_d,
    input  odv, orx_d, oFSM_state, o_error, o_frame_good, o_frame_len
  );

  modport slave (
    input  irx_dv, irx_er, irx_d,
    output odv, orx_d, oFSM_state, o_error, o_frame_good, o_frame_len
  );
endinterface

// File: rtl/eth_rx_frame_checker.sv
// Ethernet receive front end: preamble/SFD detection, byte forwarding, and
// CRC-32 / length / PHY-error checking ahead of the packet store.
module eth_rx_frame_checker #(
  parameter int pDATA_WIDTH = 8,
  parameter int pPRE_MIN    = 7,
  parameter int pMIN_LEN    = 64,
  parameter int pMAX_LEN    = 1518,
  parameter int pLEN_WIDTH  = 11
) (
  input  logic                   iclk,
  input  logic                   i_rst,
  eth_rx_frame_checker_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PREAMBLE  = 3'd1,
    S_DELIMETER = 3'd2,
    S_DATA      = 3'd3,
    S_CHECK     = 3'd4,
    S_DROP      = 3'd5
  } state_t;

  localparam int unsigned            LP_W       = pDATA_WIDTH;
  localparam logic [pDATA_WIDTH-1:0] LP_PRE     = pDATA_WIDTH'(8'h55);
  localparam logic [pDATA_WIDTH-1:0] LP_SFD     = pDATA_WIDTH'(8'hD5);
  localparam logic [3:0]             LP_PRE_MIN = 4'(pPRE_MIN);
  localparam logic [pLEN_WIDTH-1:0]  LP_MIN_LEN = pLEN_WIDTH'(pMIN_LEN);
  localparam logic [pLEN_WIDTH-1:0]  LP_MAX_LEN = pLEN_WIDTH'(pMAX_LEN);
  localparam logic [31:0]            LP_RESIDUE = 32'hDEBB20E3;

  state_t                 r_state;
  logic [3:0]             r_pre_cnt;
  logic [31:0]            r_crc;
  logic [pLEN_WIDTH-1:0]  r_len;
  logic                   r_win;
  logic                   r_odv;
  logic [pDATA_WIDTH-1:0] r_rx_d;
  logic                   r_error;
  logic                   r_frame_good;

  logic [31:0]            w_crc_next;
  logic [pLEN_WIDTH-1:0]  w_len_next;
  logic                   w_frame_bad;

  // Reflected CRC-32, data shifted in LSB first.
  function automatic logic [31:0] crc32_step(input logic [31:0]            c,
                                             input logic [pDATA_WIDTH-1:0] d);
    logic [31:0]            r;
    logic [pDATA_WIDTH-1:0] b;
    r = c;
    b = d;
    for (int unsigned i = 0; i < LP_W; i++) begin
      if (r[0] ^ b[0]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
      b = b >> 1;
    end
    return r;
  endfunction

  assign w_crc_next  = crc32_step(r_crc, bus.irx_d);
  assign w_len_next  = (&r_len) ? r_len : r_len + pLEN_WIDTH'(1);
  assign w_frame_bad = (r_crc != LP_RESIDUE) || (r_len < LP_MIN_LEN) ||
                       (r_len > LP_MAX_LEN) || (&r_len);

  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_pre_cnt    <= '0;
      r_crc        <= '1;
      r_len        <= '0;
      r_win        <= 1'b0;
      r_odv        <= 1'b0;
      r_rx_d       <= '0;
      r_error      <= 1'b0;
      r_frame_good <= 1'b0;
    end else begin
      r_rx_d       <= bus.irx_d;
      r_frame_good <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_odv   <= 1'b0;
          r_error <= 1'b0;
          if (bus.irx_dv && bus.irx_d == LP_PRE) begin
            r_state   <= S_PREAMBLE;
            r_pre_cnt <= 4'd1;
          end
        end
        S_PREAMBLE: begin
          if (bus.irx_er) begin
            r_state <= S_DROP;
            r_error <= 1'b1;
            r_win   <= 1'b0;
          end else if (!bus.irx_dv) begin
            r_state <= S_IDLE;
          end else if (bus.irx_d == LP_PRE) begin
            if (r_pre_cnt != 4'hF) r_pre_cnt <= r_pre_cnt + 4'd1;
          end else if (bus.irx_d == LP_SFD && r_pre_cnt >= LP_PRE_MIN) begin
            r_state <= S_DELIMETER;
            r_odv   <= 1'b1;
            r_crc   <= '1;
            r_len   <= '0;
          end else begin
            r_state <= S_DROP;
            r_error <= 1'b1;
            r_win   <= 1'b0;
          end
        end
        // DELIMETER and DATA share handling: the byte after the SFD is data.
        S_DELIMETER, S_DATA: begin
          if (!bus.irx_dv) begin
            r_state      <= S_CHECK;
            r_odv        <= 1'b0;
            r_win        <= 1'b0;
            r_error      <= w_frame_bad;
            r_frame_good <= !w_frame_bad;
          end else if (bus.irx_er) begin
            r_state <= S_DROP;
            r_odv   <= 1'b0;
            r_error <= 1'b1;
            r_win   <= 1'b0;
          end else begin
            r_state <= S_DATA;
            r_odv   <= 1'b1;
            r_len   <= w_len_next;
            r_crc   <= w_crc_next;
          end
        end
        S_CHECK: begin
          r_odv <= 1'b0;
          if (!r_win) begin
            r_win <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_error <= 1'b0;
          end
        end
        S_DROP: begin
          // Error window is always two cycles, even if the line idles at once.
          r_odv <= 1'b0;
          if (!r_win) begin
            r_win <= 1'b1;
          end else begin
            r_error <= 1'b0;
            if (!bus.irx_dv) r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_odv   <= 1'b0;
          r_error <= 1'b0;
        end
      endcase
    end
  end

  assign bus.odv          = r_odv;
  assign bus.orx_d        = r_rx_d;
  assign bus.oFSM_state   = r_state;
  assign bus.o_error      = r_error;
  assign bus.o_frame_good = r_frame_good;
  assign bus.o_frame_len  = r_len;

endmodule

// File: tb/tb_eth_rx_frame_checker.sv
// Directed bench for eth_rx_frame_checker: per-byte forwarding scoreboard plus
// per-frame expectation queue checked after each frame's idle gap.
module tb_eth_rx_frame_checker;
  localparam int DW = 8;
  localparam int LW = 11;

  logic iclk = 1'b0;
  logic i_rst;
  always #5 iclk = ~iclk;

  eth_rx_frame_checker_if #(.pDATA_WIDTH(DW), .pLEN_WIDTH(LW)) bus_if();

  eth_rx_frame_checker #(
    .pDATA_WIDTH(DW), .pPRE_MIN(7), .pMIN_LEN(64), .pMAX_LEN(1518), .pLEN_WIDTH(LW)
  ) dut (
    .iclk (iclk),
    .i_rst(i_rst),
    .bus  (bus_if)
  );

  typedef struct { logic fwd; logic [7:0] d; } beat_t;
  typedef struct { int good; int len; int err; int chk; int odv; int delim; int drop; } frame_exp_t;

  beat_t      beat_q[$];
  frame_exp_t exp_q[$];
  logic [7:0] frm[$];

  int n_cmp = 0;
  int n_fail = 0;
  int n_odv, n_delim, n_chk, n_drop, n_err, n_good, len_chk;
  logic [2:0] prev_state = 3'd0;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_counters();
    n_odv = 0; n_delim = 0; n_chk = 0; n_drop = 0; n_err = 0; n_good = 0; len_chk = -1;
  endtask

  task automatic step();
    beat_t b;
    @(posedge iclk); #1;
    if (beat_q.size() > 0) begin
      b = beat_q.pop_front();
      cmp("odv", bus_if.odv, b.fwd);
      if (b.fwd) cmp("orx_d", bus_if.orx_d, b.d);
    end
    if (bus_if.odv) n_odv++;
    if (bus_if.oFSM_state == 3'd2) n_delim++;
    if (bus_if.oFSM_state == 3'd4) begin
      n_chk++;
      if (prev_state != 3'd4) len_chk = int'(bus_if.o_frame_len);
    end
    if (bus_if.oFSM_state == 3'd5) n_drop++;
    if (bus_if.o_error) n_err++;
    if (bus_if.o_frame_good) begin
      n_good++;
      cmp("good_first_check", (bus_if.oFSM_state == 3'd4) && (prev_state != 3'd4), 1);
    end
    prev_state = bus_if.oFSM_state;
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d, input logic fwd);
    beat_t b;
    bus_if.irx_dv = dv;
    bus_if.irx_er = er;
    bus_if.irx_d  = d;
    b.fwd = fwd;
    b.d   = d;
    beat_q.push_back(b);
    step();
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Payload followed by FCS (complemented CRC, least significant byte first).
  task automatic build(input int n_payload, input int seed, input int flip_at);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = '1;
    for (int i = 0; i < n_payload; i++) begin
      b = 8'((i * 37 + seed * 11 + 3) & 255);
      frm.push_back(b);
      c = crc_byte(c, b);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
    if (flip_at >= 0) frm[flip_at] = frm[flip_at] ^ 8'h08;
  endtask

  // er_at: 1-based data byte carrying irx_er (0 = none).
  task automatic send(input int npre, input int er_at);
    logic ok;
    ok = (npre >= 7);
    for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55, 1'b0);
    drive(1'b1, 1'b0, 8'hD5, ok);
    for (int i = 1; i <= frm.size(); i++)
      drive(1'b1, (i == er_at), frm[i-1], ok && (er_at == 0 || i < er_at));
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic push_exp(input int good, input int len, input int err, input int chk,
                          input int odv, input int delim, input int drop);
    frame_exp_t e;
    e.good = good; e.len = len; e.err = err; e.chk = chk;
    e.odv = odv; e.delim = delim; e.drop = drop;
    exp_q.push_back(e);
  endtask

  task automatic check_frame(input string tag);
    frame_exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s: observed no expectation expected one queued", tag);
    end else begin
      e = exp_q.pop_front();
      cmp({tag, ".good"},  n_good,  e.good);
      cmp({tag, ".check"}, n_chk,   e.chk);
      cmp({tag, ".odv"},   n_odv,   e.odv);
      cmp({tag, ".delim"}, n_delim, e.delim);
      if (e.len  >= 0) cmp({tag, ".len"},  len_chk, e.len);
      if (e.err  >= 0) cmp({tag, ".err"},  n_err,   e.err);
      if (e.drop >= 0) cmp({tag, ".drop"}, n_drop,  e.drop);
    end
    clear_counters();
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, ".state"}, bus_if.oFSM_state,   3'd0);
    cmp({tag, ".odv"},   bus_if.odv,          1'b0);
    cmp({tag, ".err"},   bus_if.o_error,      1'b0);
    cmp({tag, ".good"},  bus_if.o_frame_good, 1'b0);
    cmp({tag, ".orx_d"}, bus_if.orx_d,        8'h00);
    cmp({tag, ".len"},   bus_if.o_frame_len,  11'd0);
  endtask

  initial begin
    bus_if.irx_dv = 1'b0;
    bus_if.irx_er = 1'b0;
    bus_if.irx_d  = 8'h00;
    i_rst = 1'b0;
    clear_counters();
    #1 i_rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(posedge iclk); @(posedge iclk); #1;
    i_rst = 1'b0;
    gap(4);
    clear_counters();

    build(60, 1, -1);
    push_exp(1, 64, 0, 2, 65, 1, 0);
    send(7, 0); gap(16); check_frame("good64");

    build(60, 1, 10);
    push_exp(0, 64, 2, 2, 65, 1, 0);
    send(7, 0); gap(16); check_frame("bitflip");

    build(16, 2, -1);
    push_exp(0, 20, 2, 2, 21, 1, 0);
    send(7, 0); gap(16); check_frame("runt20");

    build(59, 9, -1);
    push_exp(0, 63, 2, 2, 64, 1, 0);
    send(7, 0); gap(16); check_frame("runt63");

    build(1514, 11, -1);
    push_exp(1, 1518, 0, 2, 1519, 1, 0);
    send(7, 0); gap(16); check_frame("max1518");

    build(1515, 10, -1);
    push_exp(0, 1519, 2, 2, 1520, 1, 0);
    send(7, 0); gap(16); check_frame("long1519");

    build(96, 3, -1);
    push_exp(0, -1, 2, 0, 30, 1, 71);
    send(7, 30); gap(16); check_frame("rx_er");

    build(10, 4, -1);
    push_exp(0, -1, 2, 0, 0, 0, 15);
    send(3, 0); gap(16); check_frame("short_pre");

    build(60, 5, -1);
    push_exp(1, 64, 0, 2, 65, 1, 0);
    send(7, 0); gap(12); check_frame("b2b_a");

    build(100, 6, -1);
    push_exp(1, 104, 0, 2, 105, 1, 0);
    send(20, 0); gap(12); check_frame("b2b_b");

    build(60, 8, -1);
    push_exp(0, -1, -1, 0, 31, 1, -1);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55, 1'b0);
    drive(1'b1, 1'b0, 8'hD5, 1'b1);
    for (int i = 1; i <= 30; i++) drive(1'b1, 1'b0, frm[i-1], 1'b1);
    i_rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    drive(1'b1, 1'b0, frm[30], 1'b0);
    drive(1'b1, 1'b0, frm[31], 1'b0);
    i_rst = 1'b0;
    for (int i = 33; i <= frm.size(); i++) drive(1'b1, 1'b0, frm[i-1], 1'b0);
    gap(16); check_frame("rst_mid_frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
